// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: sits between decode and execute. It drives the register
// file read addresses, selects the operands and captures them with the
// instruction and PC in a valid/ready pipeline register. It also stalls for
// one cycle on a load-use hazard.
// Build option: OPERAND_BYPASS_EN. When defined, a writeback landing this
// cycle is forwarded into the operands. When undefined, the stage stalls
// until the write has reached the register file.
module operand_fetch_stage #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Flush,
  input  logic                      i_Valid,
  output logic                      o_Ready,
  input  logic [31:0]               i_Instruction,
  input  logic [XLEN-1:0]           i_PC,
  output logic [REG_ADDR_WIDTH-1:0] o_Read_Addr_1,
  output logic [REG_ADDR_WIDTH-1:0] o_Read_Addr_2,
  input  logic [XLEN-1:0]           i_Read_Data_1,
  input  logic [XLEN-1:0]           i_Read_Data_2,
  input  logic                      i_Wb_Write_Enable,
  input  logic [REG_ADDR_WIDTH-1:0] i_Wb_Write_Addr,
  input  logic [XLEN-1:0]           i_Wb_Write_Data,
  input  logic                      i_Ex_Is_Load,
  input  logic [REG_ADDR_WIDTH-1:0] i_Ex_Rd,
  output logic                      o_Valid,
  input  logic                      i_Ready,
  output logic [31:0]               o_Instruction,
  output logic [XLEN-1:0]           o_PC,
  output logic [XLEN-1:0]           o_Rs1_Data,
  output logic [XLEN-1:0]           o_Rs2_Data
);

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic                      wb_hit_1;
  logic                      wb_hit_2;
  logic                      load_hazard;
  logic                      wb_hazard;
  logic                      advance;
  logic                      accept;
  logic [XLEN-1:0]           operand_1;
  logic [XLEN-1:0]           operand_2;

  logic                      valid_q, valid_d;
  logic [31:0]               instr_q, instr_d;
  logic [XLEN-1:0]           pc_q, pc_d;
  logic [XLEN-1:0]           rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]           rs2_data_q, rs2_data_d;

  // Source register fields go straight to the register file, independent of i_Valid.
  assign rs1           = i_Instruction[19:15];
  assign rs2           = i_Instruction[24:20];
  assign o_Read_Addr_1 = rs1;
  assign o_Read_Addr_2 = rs2;

  // A writeback to x0 never matches, so x0 always reads as zero.
  assign wb_hit_1 = i_Wb_Write_Enable && (i_Wb_Write_Addr != '0) && (i_Wb_Write_Addr == rs1);
  assign wb_hit_2 = i_Wb_Write_Enable && (i_Wb_Write_Addr != '0) && (i_Wb_Write_Addr == rs2);

  // rs2 is compared even for formats that have no rs2; the occasional false stall is harmless.
  assign load_hazard = i_Valid && i_Ex_Is_Load && (i_Ex_Rd != '0) &&
                       ((i_Ex_Rd == rs1) || (i_Ex_Rd == rs2));

`ifdef OPERAND_BYPASS_EN
  // Forward the writeback value so the operand does not wait for the write edge.
  assign operand_1 = wb_hit_1 ? i_Wb_Write_Data : i_Read_Data_1;
  assign operand_2 = wb_hit_2 ? i_Wb_Write_Data : i_Read_Data_2;
  assign wb_hazard = 1'b0;
`else
  // No forwarding path, so hold the instruction for one cycle until the write has landed.
  logic unused_wb_data;
  assign unused_wb_data = ^i_Wb_Write_Data;
  assign operand_1      = i_Read_Data_1;
  assign operand_2      = i_Read_Data_2;
  assign wb_hazard      = i_Valid && (wb_hit_1 || wb_hit_2);
`endif

  assign advance = !valid_q || i_Ready;
  assign o_Ready = advance && !load_hazard && !wb_hazard && !i_Flush && !i_Reset;
  assign accept  = i_Valid && o_Ready;

  // Next state of the pipeline register: flush, then load or bubble, else hold.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    if (i_Flush) begin
      valid_d = 1'b0;
    end else if (advance) begin
      if (accept) begin
        valid_d    = 1'b1;
        instr_d    = i_Instruction;
        pc_d       = i_PC;
        rs1_data_d = operand_1;
        rs2_data_d = operand_2;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Pipeline register with synchronous reset to an invalid NOP.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  assign o_Valid       = valid_q;
  assign o_Instruction = instr_q;
  assign o_PC          = pc_q;
  assign o_Rs1_Data    = rs1_data_q;
  assign o_Rs2_Data    = rs2_data_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an architectural model.
// The model holds a register file and computes each captured operand as the
// newest register value, including a write that lands this cycle.
module tb_operand_fetch_stage;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_Reset, i_Flush, i_Valid, i_Ready;
  logic        i_Wb_Write_Enable, i_Ex_Is_Load;
  logic [31:0] i_Instruction, i_PC, i_Wb_Write_Data;
  logic [4:0]  i_Wb_Write_Addr, i_Ex_Rd;
  logic [31:0] i_Read_Data_1, i_Read_Data_2;
  logic        o_Ready, o_Valid;
  logic [4:0]  o_Read_Addr_1, o_Read_Addr_2;
  logic [31:0] o_Instruction, o_PC, o_Rs1_Data, o_Rs2_Data;

  int checks = 0;
  int errors = 0;

  operand_fetch_stage #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .i_Clock(clk), .i_Reset(i_Reset), .i_Flush(i_Flush), .i_Valid(i_Valid),
    .o_Ready(o_Ready), .i_Instruction(i_Instruction), .i_PC(i_PC),
    .o_Read_Addr_1(o_Read_Addr_1), .o_Read_Addr_2(o_Read_Addr_2),
    .i_Read_Data_1(i_Read_Data_1), .i_Read_Data_2(i_Read_Data_2),
    .i_Wb_Write_Enable(i_Wb_Write_Enable), .i_Wb_Write_Addr(i_Wb_Write_Addr),
    .i_Wb_Write_Data(i_Wb_Write_Data), .i_Ex_Is_Load(i_Ex_Is_Load), .i_Ex_Rd(i_Ex_Rd),
    .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Instruction(o_Instruction), .o_PC(o_PC),
    .o_Rs1_Data(o_Rs1_Data), .o_Rs2_Data(o_Rs2_Data)
  );

  // Architectural register file. The bench plays the register file towards the DUT.
  logic [31:0] regs [32];
  logic [4:0]  tb_rs1, tb_rs2;
  assign tb_rs1 = i_Instruction[19:15];
  assign tb_rs2 = i_Instruction[24:20];

  always_comb begin
    i_Read_Data_1 = (tb_rs1 == 5'd0) ? 32'd0 : regs[tb_rs1];
    i_Read_Data_2 = (tb_rs2 == 5'd0) ? 32'd0 : regs[tb_rs2];
  end

  // Newest value of a register, counting a write that lands at this edge.
  function automatic logic [31:0] newest(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (i_Wb_Write_Enable && i_Wb_Write_Addr == r) return i_Wb_Write_Data;
    return regs[r];
  endfunction

  // Expected model state
  logic        model_live;
  logic        exp_valid, exp_fresh, exp_ready;
  logic [31:0] exp_instr, exp_pc, exp_rs1, exp_rs2;

  // The stage can take an instruction unless something blocks it.
  always_comb begin
    logic blocked;
    blocked = i_Reset || i_Flush || (exp_valid && !i_Ready);
    if (i_Valid && i_Ex_Is_Load && i_Ex_Rd != 5'd0 && (i_Ex_Rd == tb_rs1 || i_Ex_Rd == tb_rs2))
      blocked = 1'b1;
`ifndef OPERAND_BYPASS_EN
    if (i_Valid && i_Wb_Write_Enable && i_Wb_Write_Addr != 5'd0 &&
        (i_Wb_Write_Addr == tb_rs1 || i_Wb_Write_Addr == tb_rs2))
      blocked = 1'b1;
`endif
    exp_ready = !blocked;
  end

  always @(posedge clk) begin
    if (i_Reset) begin
      model_live <= 1'b1;
      exp_valid  <= 1'b0;
      exp_fresh  <= 1'b1;
      exp_instr  <= NOP_INSTR;
      exp_pc     <= 32'd0;
      exp_rs1    <= 32'd0;
      exp_rs2    <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
    end else begin
      if (i_Wb_Write_Enable && i_Wb_Write_Addr != 5'd0) regs[i_Wb_Write_Addr] <= i_Wb_Write_Data;
      if (i_Flush) begin
        exp_valid <= 1'b0;
      end else if (!exp_valid || i_Ready) begin
        if (i_Valid && exp_ready) begin
          exp_valid <= 1'b1;
          exp_fresh <= 1'b0;
          exp_instr <= i_Instruction;
          exp_pc    <= i_PC;
          exp_rs1   <= newest(tb_rs1);
          exp_rs2   <= newest(tb_rs2);
        end else begin
          exp_valid <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the model.
  task automatic model_check();
    if (model_live === 1'b1) begin
      chk("model_o_Valid", 32'(o_Valid), 32'(exp_valid));
      chk("model_o_Ready", 32'(o_Ready), 32'(exp_ready));
      chk("model_o_Read_Addr_1", 32'(o_Read_Addr_1), 32'(tb_rs1));
      chk("model_o_Read_Addr_2", 32'(o_Read_Addr_2), 32'(tb_rs2));
      if (exp_valid || exp_fresh) begin
        chk("model_o_Instruction", o_Instruction, exp_instr);
        chk("model_o_PC", o_PC, exp_pc);
        chk("model_o_Rs1_Data", o_Rs1_Data, exp_rs1);
        chk("model_o_Rs2_Data", o_Rs2_Data, exp_rs2);
      end
    end
  endtask

  // One clock: model check at the falling edge, then return 1 ns after the rising edge.
  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic ready_is(input string name, input logic exp);
    #1;
    chk(name, 32'(o_Ready), 32'(exp));
  endtask

  initial begin
    logic [31:0] r;
    i_Reset = 1'b1; i_Flush = 1'b0; i_Valid = 1'b1; i_Ready = 1'b1;
    i_Instruction = 32'h002081B3; i_PC = 32'h0;
    i_Wb_Write_Enable = 1'b0; i_Wb_Write_Addr = 5'd0; i_Wb_Write_Data = 32'd0;
    i_Ex_Is_Load = 1'b0; i_Ex_Rd = 5'd0;

    // Reset held two cycles with i_Valid high
    ready_is("reset_o_Ready", 1'b0);
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("reset_o_Valid", 32'(o_Valid), 32'd0);
      chk("reset_o_Instruction", o_Instruction, NOP_INSTR);
    end

    // Release reset and load x1=5, x2=7 through the writeback port
    i_Reset = 1'b0; i_Valid = 1'b0;
    i_Wb_Write_Enable = 1'b1; i_Wb_Write_Addr = 5'd1; i_Wb_Write_Data = 32'd5;
    ready_is("post_reset_o_Ready", 1'b1);
    cycle();
    i_Wb_Write_Addr = 5'd2; i_Wb_Write_Data = 32'd7;
    cycle();
    i_Wb_Write_Enable = 1'b0;

    // Three back-to-back ADD x3,x1,x2
    i_Valid = 1'b1; i_Instruction = 32'h002081B3;
    for (int k = 0; k < 3; k++) begin
      i_PC = 32'h100 + 32'(4 * k);
      cycle();
      chk("stream_o_Valid", 32'(o_Valid), 32'd1);
      chk("stream_o_PC", o_PC, 32'h100 + 32'(4 * k));
      chk("stream_o_Rs1_Data", o_Rs1_Data, 32'd5);
      chk("stream_o_Rs2_Data", o_Rs2_Data, 32'd7);
    end
    i_Valid = 1'b0;
    cycle();

    // Writeback to the source register in the same cycle (ADDI x5,x4,0)
    i_Wb_Write_Enable = 1'b1; i_Wb_Write_Addr = 5'd4; i_Wb_Write_Data = 32'd1;
    cycle();
    i_Valid = 1'b1; i_Instruction = 32'h00020293; i_PC = 32'h200;
    i_Wb_Write_Data = 32'hDEADBEEF;
`ifdef OPERAND_BYPASS_EN
    ready_is("bypass_o_Ready", 1'b1);
    cycle();
    i_Wb_Write_Enable = 1'b0;
`else
    ready_is("wb_stall_o_Ready", 1'b0);
    cycle();
    chk("wb_stall_bubble_o_Valid", 32'(o_Valid), 32'd0);
    i_Wb_Write_Enable = 1'b0;
    ready_is("wb_stall_release_o_Ready", 1'b1);
    cycle();
`endif
    chk("bypass_o_Valid", 32'(o_Valid), 32'd1);
    chk("bypass_o_Rs1_Data", o_Rs1_Data, 32'hDEADBEEF);

    // A write to x0 is never forwarded (ADDI x5,x0,0)
    i_Instruction = 32'h00000293; i_PC = 32'h204;
    i_Wb_Write_Enable = 1'b1; i_Wb_Write_Addr = 5'd0; i_Wb_Write_Data = 32'hDEADBEEF;
    ready_is("x0_o_Ready", 1'b1);
    cycle();
    chk("x0_o_Rs1_Data", o_Rs1_Data, 32'd0);
    i_Wb_Write_Enable = 1'b0;

    // Load-use on rs2 (ADD x7,x1,x6 with a load to x6 in execute)
    i_Ex_Is_Load = 1'b1; i_Ex_Rd = 5'd6; i_Instruction = 32'h006083B3; i_PC = 32'h208;
    ready_is("load_use_o_Ready", 1'b0);
    cycle();
    chk("load_use_bubble_o_Valid", 32'(o_Valid), 32'd0);
    i_Ex_Is_Load = 1'b0;
    ready_is("load_use_release_o_Ready", 1'b1);
    cycle();
    chk("load_use_o_Instruction", o_Instruction, 32'h006083B3);
    chk("load_use_o_Rs2_Data", o_Rs2_Data, 32'h1000_0006);

    // A load to x0 never stalls
    i_Ex_Is_Load = 1'b1; i_Ex_Rd = 5'd0; i_Instruction = 32'h00000293; i_PC = 32'h20C;
    ready_is("load_x0_o_Ready", 1'b1);
    cycle();
    chk("load_x0_o_PC", o_PC, 32'h20C);
    i_Ex_Is_Load = 1'b0;

    // Backpressure for three cycles, then a flush
    i_Ready = 1'b0; i_Instruction = 32'h002081B3; i_PC = 32'h300;
    for (int k = 0; k < 3; k++) begin
      ready_is("stall_o_Ready", 1'b0);
      cycle();
      chk("stall_o_Valid", 32'(o_Valid), 32'd1);
      chk("stall_o_PC", o_PC, 32'h20C);
    end
    i_Flush = 1'b1;
    ready_is("flush_o_Ready", 1'b0);
    cycle();
    chk("flush_o_Valid", 32'(o_Valid), 32'd0);
    i_Flush = 1'b0; i_Ready = 1'b1;

    // Reset in the middle of a load-use stall
    i_Ex_Is_Load = 1'b1; i_Ex_Rd = 5'd1;
    cycle();
    i_Reset = 1'b1;
    cycle();
    chk("mid_reset_o_Valid", 32'(o_Valid), 32'd0);
    chk("mid_reset_o_Instruction", o_Instruction, NOP_INSTR);
    chk("mid_reset_o_Rs1_Data", o_Rs1_Data, 32'd0);
    i_Reset = 1'b0; i_Ex_Is_Load = 1'b0;

    // Randomized traffic, with small register numbers to make hazards frequent
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      i_Instruction     = r;
      i_PC              = $urandom;
      i_Reset           = ($urandom_range(0, 63) == 0);
      i_Flush           = ($urandom_range(0, 15) == 0);
      i_Valid           = ($urandom_range(0, 3) != 0);
      i_Ready           = ($urandom_range(0, 3) != 0);
      i_Wb_Write_Enable = ($urandom_range(0, 1) == 1);
      i_Wb_Write_Addr   = 5'($urandom_range(0, 7));
      i_Wb_Write_Data   = $urandom;
      i_Ex_Is_Load      = ($urandom_range(0, 3) == 0);
      i_Ex_Rd           = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
Pipeline stage between instruction decode and execute in the RV32 core.
- Takes a decoded instruction, drives the register file's two read-address ports and captures the operands into a valid/ready pipeline register.
- Resolves writeback-to-read hazards, since a register file write only lands at the clock edge.
- Inserts a one-cycle bubble on load-use hazards.

Parameters:
XLEN, 32, data/PC width (from cpu_core_params)
REG_ADDR_WIDTH, 5, register address width (from cpu_core_params)

Ports:
i_Clock  in  1  clock
i_Reset  in  1  synchronous active-high reset
i_Flush  in  1  kill the held instruction and any accept this cycle
i_Valid  in  1  upstream instruction valid
o_Ready  out  1  stage can accept upstream instruction
i_Instruction  in  32  instruction word
i_PC  in  XLEN  instruction PC
o_Read_Addr_1  out  REG_ADDR_WIDTH  register file port 1 address = i_Instruction[19:15]
o_Read_Addr_2  out  REG_ADDR_WIDTH  register file port 2 address = i_Instruction[24:20]
i_Read_Data_1  in  XLEN  register file port 1 data (combinational; returns 0 for x0)
i_Read_Data_2  in  XLEN  register file port 2 data
i_Wb_Write_Enable  in  1  writeback writing this cycle (same signal as the register file write enable)
i_Wb_Write_Addr  in  REG_ADDR_WIDTH  writeback destination
i_Wb_Write_Data  in  XLEN  writeback data
i_Ex_Is_Load  in  1  instruction in execute is a valid load
i_Ex_Rd  in  REG_ADDR_WIDTH  execute-stage destination
o_Valid  out  1  output register holds a valid instruction
i_Ready  in  1  downstream accepts
o_Instruction  out  32  registered instruction
o_PC  out  XLEN  registered PC
o_Rs1_Data  out  XLEN  registered operand 1
o_Rs2_Data  out  XLEN  registered operand 2

Behaviour:
- Clock and reset: single clock i_Clock; reset i_Reset is synchronous, active-high.
- Reset values: o_Valid=0; o_Instruction=32'h00000013 (NOP); o_PC, o_Rs1_Data, o_Rs2_Data = 0.
- Read addresses: o_Read_Addr_1/2 are purely combinational from i_Instruction; they do not depend on i_Valid.
- Load-use hazard:
  - load_hazard = i_Valid && i_Ex_Is_Load && i_Ex_Rd!=0 && (i_Ex_Rd==rs1 || i_Ex_Rd==rs2).
  - rs2 is always compared, even for formats without rs2; resulting false stalls are accepted.
- Advance: advance = !o_Valid || i_Ready.
- Ready: o_Ready = advance && !load_hazard && !i_Flush && !i_Reset.
- Accept: accept = i_Valid && o_Ready.
- Bypass, per operand:
  - If i_Wb_Write_Enable && i_Wb_Write_Addr!=0 && i_Wb_Write_Addr==rsN, operand = i_Wb_Write_Data.
  - Otherwise operand = i_Read_Data_N.
  - x0 is never bypassed; operand stays 0.
- Register update, in priority order:
  1. i_Reset: reset values.
  2. i_Flush: o_Valid<=0; data registers unchanged.
  3. advance && accept: load instruction, PC and both operands; o_Valid<=1.
  4. advance && !accept: o_Valid<=0 (bubble); data registers may hold.
  5. !advance: all registers hold. Output is stable while o_Valid && !i_Ready.
- Latency: 1 cycle from accept to o_Valid. Throughput 1/cycle with no hazard.
- Load-use: the stall lasts exactly as long as the hazard condition persists. Execute advancing clears i_Ex_Is_Load, so a single load costs 1 bubble.
- Simultaneous flush and i_Valid: instruction not accepted (o_Ready=0); upstream must hold or be flushed itself.
- Reset mid-stall: outputs return to reset values next edge; no residual state.

Optional Feature:
Macro OPERAND_BYPASS_EN.
- Defined: writeback bypass as specified.
- Undefined:
  - No bypass mux; operands always come from i_Read_Data_N.
  - Additional hazard wb_hazard = i_Valid && i_Wb_Write_Enable && i_Wb_Write_Addr!=0 && i_Wb_Write_Addr matches rs1 or rs2.
  - wb_hazard is ORed into the stall term of o_Ready, costing one bubble until the write lands in the register file.

Test Plan:
- Reset held 2 cycles with i_Valid=1 -> o_Valid=0, o_Instruction=32'h00000013, o_Ready=0; first cycle after release o_Ready=1.
- Back-to-back: ADD x3,x1,x2 with i_Read_Data_1=5, i_Read_Data_2=7, i_Ready=1 -> next cycle o_Valid=1, o_Rs1_Data=5, o_Rs2_Data=7; three instructions stream with no bubbles.
- Bypass: rs1=x4, i_Read_Data_1=1, i_Wb_Write_Enable=1, i_Wb_Write_Addr=4, data 32'hDEADBEEF -> o_Rs1_Data=DEADBEEF. Same test with Wb addr 0 -> o_Rs1_Data=0 for rs1=x0.
- Load-use: i_Ex_Is_Load=1, i_Ex_Rd=6, instruction with rs2=x6 -> o_Ready=0 for 1 cycle and bubble (o_Valid=0); accepted when i_Ex_Is_Load drops. i_Ex_Rd=0 -> no stall.
- Backpressure: o_Valid=1, i_Ready=0 for 3 cycles -> outputs stable, o_Ready=0; i_Flush pulse -> o_Valid=0 next cycle, no accept that cycle.
- Without OPERAND_BYPASS_EN: the bypass scenario instead gives o_Ready=0 for 1 cycle, then captures the register file value.
